// File: rtl/sramlike_bus_arbiter_if.sv
// One sram-like port: request fields toward the slave, handshakes and read data back.
interface sramlike_bus_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        addr_ok;
  logic        data_ok;

  modport master (
    output req, wr, size, addr, wdata,
    input  rdata, addr_ok, data_ok
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output rdata, addr_ok, data_ok
  );
endinterface

// File: rtl/sramlike_bus_arbiter.sv
// Two-master sram-like arbiter: one outstanding transaction, data has fixed
// priority, inst is forced through after STARVE_LIMIT consecutive data grants.
module sramlike_bus_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  sramlike_bus_arbiter_if.slave  inst_io,
  sramlike_bus_arbiter_if.slave  data_io,
  sramlike_bus_arbiter_if.master bus_io
);

  localparam int   CNT_W    = $clog2(STARVE_LIMIT + 1);
  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic [CNT_W-1:0] starve_q, starve_d;

  logic starve_hit;
  logic sel_inst;
  logic bus_req;
  logic aok_own;
  logic dok_own;

  assign starve_hit = (starve_q == CNT_W'(STARVE_LIMIT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      owner_q  <= OWN_INST;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    starve_d = starve_q;
    bus_req  = 1'b0;
    aok_own  = 1'b0;
    dok_own  = 1'b0;
    case (state_q)
      IDLE: begin
        if (inst_io.req || data_io.req) begin
          state_d = ADDR;
          if (data_io.req && !(inst_io.req && starve_hit)) begin
            owner_d = OWN_DATA;
            // The counter only tracks data grants that made a waiting inst wait longer.
            if (!inst_io.req) begin
              starve_d = '0;
            end else if (!starve_hit) begin
              starve_d = starve_q + 1'b1;
            end
          end else begin
            owner_d  = OWN_INST;
            starve_d = '0;
          end
        end
      end
      ADDR: begin
        bus_req = (owner_q == OWN_DATA) ? data_io.req : inst_io.req;
        if (bus_io.addr_ok) begin
          aok_own = 1'b1;
          if (bus_io.data_ok) begin
            dok_own = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (bus_io.data_ok) begin
          dok_own = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outside ADDR the bus fields simply follow the data master.
  assign sel_inst = (state_q == ADDR) && (owner_q == OWN_INST);

  assign bus_io.req   = bus_req;
  assign bus_io.wr    = sel_inst ? inst_io.wr    : data_io.wr;
  assign bus_io.size  = sel_inst ? inst_io.size  : data_io.size;
  assign bus_io.addr  = sel_inst ? inst_io.addr  : data_io.addr;
  assign bus_io.wdata = sel_inst ? inst_io.wdata : data_io.wdata;

  assign inst_io.addr_ok = aok_own && (owner_q == OWN_INST);
  assign inst_io.data_ok = dok_own && (owner_q == OWN_INST);
  assign data_io.addr_ok = aok_own && (owner_q == OWN_DATA);
  assign data_io.data_ok = dok_own && (owner_q == OWN_DATA);

  assign inst_io.rdata = bus_io.rdata;
  assign data_io.rdata = bus_io.rdata;

endmodule

// File: tb/tb_sramlike_bus_arbiter.sv
// Scoreboard bench: master/slave models drive the arbiter, a monitor pops
// expected transactions on every handshake and compares routing and data.
module tb_sramlike_bus_arbiter;
  localparam int STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sramlike_bus_arbiter_if inst_if ();
  sramlike_bus_arbiter_if data_if ();
  sramlike_bus_arbiter_if bus_if ();

  sramlike_bus_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk    (clk),
    .rst    (rst),
    .inst_io(inst_if),
    .data_io(data_if),
    .bus_io (bus_if)
  );

  typedef struct {
    logic        m;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  txn_t mq0[$];
  txn_t mq1[$];
  txn_t exp_a[$];
  txn_t exp_d[$];
  int   rise_log[$];
  int   dok_log[$];
  int   combo_log[$];

  // ---------------- master models ----------------
  logic        m_req   [2];
  logic        m_wr    [2];
  logic [1:0]  m_size  [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  int          drv_cyc [2];

  assign inst_if.req   = m_req[0];
  assign inst_if.wr    = m_wr[0];
  assign inst_if.size  = m_size[0];
  assign inst_if.addr  = m_addr[0];
  assign inst_if.wdata = m_wdata[0];
  assign data_if.req   = m_req[1];
  assign data_if.wr    = m_wr[1];
  assign data_if.size  = m_size[1];
  assign data_if.addr  = m_addr[1];
  assign data_if.wdata = m_wdata[1];

  initial begin
    logic done [2];
    txn_t t;
    bit   has;
    for (int i = 0; i < 2; i++) begin
      m_req[i] = 1'b0; m_wr[i] = 1'b0; m_size[i] = 2'b00;
      m_addr[i] = 32'h0; m_wdata[i] = 32'h0; drv_cyc[i] = 0; done[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      done[0] = m_req[0] && inst_if.addr_ok;
      done[1] = m_req[1] && data_if.addr_ok;
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (done[i]) begin
          if (i == 0) void'(mq0.pop_front());
          else        void'(mq1.pop_front());
        end
        has = (i == 0) ? (mq0.size() > 0) : (mq1.size() > 0);
        if (has) begin
          t = (i == 0) ? mq0[0] : mq1[0];
          if (!m_req[i]) drv_cyc[i] = cyc;
          m_req[i] = 1'b1; m_wr[i] = t.wr; m_size[i] = t.size;
          m_addr[i] = t.addr; m_wdata[i] = t.wdata;
        end else begin
          m_req[i] = 1'b0;
        end
      end
    end
  end

  // ---------------- slave model ----------------
  logic        slv_aok = 1'b0;
  logic        slv_dok = 1'b0;
  logic        force_dok = 1'b0;
  logic [31:0] slv_rdata = 32'h0;
  logic [31:0] slv_mem [logic [31:0]];
  logic [31:0] acc_addr = 32'h0;
  int          addr_wait = 0;
  int          data_wait = 1;
  int          slv_phase = 0;
  int          slv_cnt = 0;

  assign bus_if.addr_ok = slv_aok;
  assign bus_if.data_ok = slv_dok | force_dok;
  assign bus_if.rdata   = slv_rdata;

  task automatic slv_return();
    slv_dok   = 1'b1;
    slv_rdata = slv_mem.exists(acc_addr) ? slv_mem[acc_addr] : 32'hDEADBEEF;
    slv_phase = 0;
  endtask

  task automatic slv_accept();
    acc_addr = bus_if.addr;
    slv_aok  = 1'b1;
    if (data_wait == 0) slv_return();
    else begin slv_cnt = data_wait; slv_phase = 2; end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      slv_aok = 1'b0;
      slv_dok = 1'b0;
      if (!rst) begin
        slv_phase = 0;
      end else begin
        case (slv_phase)
          0: if (bus_if.req) begin
               if (addr_wait == 0) slv_accept();
               else begin slv_cnt = addr_wait; slv_phase = 1; end
             end
          1: begin slv_cnt--; if (slv_cnt == 0) slv_accept(); end
          default: begin slv_cnt--; if (slv_cnt == 0) slv_return(); end
        endcase
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail(string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  initial begin
    logic prev_req;
    txn_t e;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_if.req && !prev_req) rise_log.push_back(cyc);
      prev_req = bus_if.req;
      if ((inst_if.addr_ok || data_if.addr_ok) && !(bus_if.addr_ok && bus_if.req))
        fail("spurious_addr_ok");
      if (bus_if.addr_ok && bus_if.req) begin
        if (exp_a.size() == 0) fail("unexpected_addr_phase");
        else begin
          e = exp_a.pop_front();
          $display("addr phase: owner=%0d wr=%0b addr=%h", e.m, bus_if.wr, bus_if.addr);
          check("addr_ok_route", {30'd0, inst_if.addr_ok, data_if.addr_ok}, e.m ? 32'd1 : 32'd2);
          check("bus_addr", bus_if.addr, e.addr);
          check("bus_wr", {31'd0, bus_if.wr}, {31'd0, e.wr});
          check("bus_size", {30'd0, bus_if.size}, {30'd0, e.size});
          if (e.wr) check("bus_wdata", bus_if.wdata, e.wdata);
        end
      end
      if (inst_if.data_ok || data_if.data_ok) begin
        dok_log.push_back(cyc);
        if (bus_if.addr_ok) combo_log.push_back(cyc);
        if (exp_d.size() == 0) fail("unexpected_data_ok");
        else begin
          e = exp_d.pop_front();
          $display("data phase: owner=%0d rdata=%h", e.m, bus_if.rdata);
          check("data_ok_route", {30'd0, inst_if.data_ok, data_if.data_ok}, e.m ? 32'd1 : 32'd2);
          if (!e.wr) check("rdata", e.m ? data_if.rdata : inst_if.rdata, e.rdata);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic txn_t mk(int m, logic wr, logic [31:0] addr, logic [31:0] wdata,
                              logic [31:0] rdata);
    txn_t t;
    t.m = (m == 1); t.wr = wr; t.size = 2'b10;
    t.addr = addr; t.wdata = wdata; t.rdata = rdata;
    return t;
  endfunction

  task automatic enq(int m, logic wr, logic [31:0] addr, logic [31:0] wdata, logic [31:0] rdata);
    if (m == 0) mq0.push_back(mk(m, wr, addr, wdata, rdata));
    else        mq1.push_back(mk(m, wr, addr, wdata, rdata));
    slv_mem[addr] = rdata;
  endtask

  task automatic exp_push(int m, logic wr, logic [31:0] addr, logic [31:0] wdata,
                          logic [31:0] rdata, bit with_data);
    exp_a.push_back(mk(m, wr, addr, wdata, rdata));
    if (with_data) exp_d.push_back(mk(m, wr, addr, wdata, rdata));
  endtask

  task automatic txn(int m, logic wr, logic [31:0] addr, logic [31:0] wdata, logic [31:0] rdata);
    enq(m, wr, addr, wdata, rdata);
    exp_push(m, wr, addr, wdata, rdata, 1'b1);
  endtask

  task automatic wait_idle(string name, int budget);
    int n;
    n = 0;
    while ((mq0.size() + mq1.size() + exp_a.size() + exp_d.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      fail({name, "_timeout"});
      mq0.delete(); mq1.delete(); exp_a.delete(); exp_d.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  // ---------------- directed tests ----------------
  initial begin
    int r0, d0, c0, n;

    // T1: requests pending during reset; nothing may leak, data wins first after release
    addr_wait = 0; data_wait = 1;
    txn(1, 1'b0, 32'h8000_0000, 32'h0, 32'h1111_2222);
    enq(0, 1'b0, 32'hBFC0_0004, 32'h0, 32'h3333_4444);
    exp_push(0, 1'b0, 32'hBFC0_0004, 32'h0, 32'h3333_4444, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check("reset_outputs", {27'd0, bus_if.req, inst_if.addr_ok, inst_if.data_ok,
                              data_if.addr_ok, data_if.data_ok}, 32'd0);
    end
    rst = 1'b1;
    #1 check("release_cycle_bus_req", {31'd0, bus_if.req}, 32'd0);
    wait_idle("t1", 100);

    // T2: single inst read with a slow slave
    addr_wait = 1; data_wait = 2;
    txn(0, 1'b0, 32'hBFC0_0000, 32'h0, 32'h3C1D_BFC0);
    wait_idle("t2", 100);

    // Latency with a zero-wait slave: bus_req one cycle after the request, data_ok two
    addr_wait = 0; data_wait = 1;
    r0 = rise_log.size(); d0 = dok_log.size();
    txn(0, 1'b0, 32'hBFC0_0008, 32'h0, 32'h2408_0001);
    wait_idle("lat", 100);
    if (rise_log.size() > r0 && dok_log.size() > d0) begin
      check("lat_bus_req", rise_log[r0] - drv_cyc[0], 32'd1);
      check("lat_data_ok", dok_log[d0] - drv_cyc[0], 32'd2);
    end else fail("lat_events_missing");

    // T3: contention, data first then inst
    addr_wait = 1; data_wait = 1;
    enq(0, 1'b0, 32'hBFC0_000C, 32'h0, 32'h0000_000C);
    enq(1, 1'b0, 32'h8000_0010, 32'h0, 32'h0000_0010);
    exp_push(1, 1'b0, 32'h8000_0010, 32'h0, 32'h0000_0010, 1'b1);
    exp_push(0, 1'b0, 32'hBFC0_000C, 32'h0, 32'h0000_000C, 1'b1);
    wait_idle("t3", 100);

    // T4: starvation guard: D D D D I D D D D I D
    addr_wait = 0; data_wait = 1;
    for (int k = 0; k < 9; k++) enq(1, 1'b0, 32'h8000_0100 + 32'(4 * k), 32'h0, 32'hD000_0000 | 32'(k));
    for (int j = 0; j < 2; j++) enq(0, 1'b0, 32'hBFC0_0100 + 32'(4 * j), 32'h0, 32'h1000_0000 | 32'(j));
    for (int s = 0; s < 11; s++) begin
      if (s == 4 || s == 9) begin
        n = (s == 4) ? 0 : 1;
        exp_push(0, 1'b0, 32'hBFC0_0100 + 32'(4 * n), 32'h0, 32'h1000_0000 | 32'(n), 1'b1);
      end else begin
        n = (s < 4) ? s : ((s < 9) ? s - 1 : s - 2);
        exp_push(1, 1'b0, 32'h8000_0100 + 32'(4 * n), 32'h0, 32'hD000_0000 | 32'(n), 1'b1);
      end
    end
    wait_idle("t4", 300);

    // T5: combined addr_ok+data_ok on a data write; FSM must be back in IDLE next cycle
    addr_wait = 0; data_wait = 0;
    r0 = rise_log.size(); c0 = combo_log.size();
    txn(1, 1'b1, 32'h8000_1000, 32'hCAFE_F00D, 32'h0);
    txn(1, 1'b0, 32'h8000_1004, 32'h0, 32'h55AA_55AA);
    wait_idle("t5", 100);
    check("t5_combined_count", combo_log.size() - c0, 32'd2);
    if (rise_log.size() > r0 + 1 && combo_log.size() > c0)
      check("t5_idle_after_combined", rise_log[r0 + 1] - combo_log[c0], 32'd2);
    else fail("t5_events_missing");

    // T6: reset while inst read is in DATA; response is dropped
    addr_wait = 0; data_wait = 6;
    enq(0, 1'b0, 32'hBFC0_0010, 32'h0, 32'h7777_0000);
    exp_push(0, 1'b0, 32'hBFC0_0010, 32'h0, 32'h7777_0000, 1'b0);
    n = 0;
    while (exp_a.size() != 0 && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) fail("t6_addr_timeout");
    @(negedge clk);
    #2 rst = 1'b0; force_dok = 1'b1;
    #1 check("t6_reset_abort", {27'd0, bus_if.req, inst_if.addr_ok, inst_if.data_ok,
                                data_if.addr_ok, data_if.data_ok}, 32'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("t6_stray_data_ok", {30'd0, inst_if.data_ok, data_if.data_ok}, 32'd0);
    #2 force_dok = 1'b0;
    addr_wait = 1; data_wait = 1;
    txn(0, 1'b0, 32'hBFC0_0020, 32'h0, 32'h8FA2_0000);
    wait_idle("t6_recover", 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
